player_ctrl: RTL
================

Name: player_ctrl

Overview:
Parametrised successor to the original player ship FSM. Tracks lives, horizontal position, firing and pause/flash behaviour for the player ship. Sits between the debounced button inputs and the renderer/bullet engine. Adds configurable geometry, frame-rate movement, shot cooldown, hit-flash and level-clear handling.

Parameters:
lives_p, 3, starting lives (1..15)
screen_w_p, 640, playfield width in pixels (<=1024)
ship_w_p, 32, ship width in pixels
step_p, 4, pixels moved per frame tick
start_left_p, 304, ship left x after reset, level restart or game restart; must be <= screen_w_p-ship_w_p
cooldown_p, 16, frame ticks between shots (>=1)
flash_p, 8, frame ticks per visibility toggle while hit

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
frame_tick_i  in  1  one-cycle strobe, once per video frame
move_left_i  in  1  left button level
move_right_i  in  1  right button level
shoot_i  in  1  shoot/resume button level
hit_i  in  1  one-cycle strobe, ship hit by enemy bullet
level_clear_i  in  1  one-cycle strobe, all enemies destroyed
fire_o  out  1  one-cycle pulse, spawn player bullet
alive_o  out  1  lives > 0
lives_o  out  4  current lives
pos_left_o  out  10  ship left x
pos_right_o  out  10  pos_left_o + ship_w_p - 1 (combinational)
paused_o  out  1  game frozen (states HIT, CLEAR, DEAD)
visible_o  out  1  renderer draws ship
state_o  out  6  one-hot present state {CLEAR,DEAD,HIT,RIGHT,LEFT,IDLE}, LSB=IDLE

Behaviour:
- Reset (async, reset_ni=0): state IDLE, lives=lives_p, pos_left=start_left_p, cooldown=0, fire_o=0, visible_o=1, flash counter=0, shoot_q=1. With shoot_q=1, holding the button through reset does not fire.
- shoot_rise = shoot_i & ~shoot_q; shoot_q <= shoot_i every cycle.
- Active states (IDLE/LEFT/RIGHT), priority order:
  1. hit_i: lives-1. New lives 0 -> DEAD, else HIT. No fire, no move this cycle.
  2. level_clear_i -> CLEAR. No fire, no move.
  3. Otherwise next = LEFT if left only, RIGHT if right only, IDLE if both or neither.
- Movement: on frame_tick_i with present state LEFT, pos_left -= step_p, saturating at 0. With RIGHT, pos_left += step_p, saturating at screen_w_p-ship_w_p. Arithmetic is 11-bit to avoid wrap.
- Fire: in an active state with no hit/clear and shoot_rise and cooldown==0 -> fire_o=1 for exactly one cycle and cooldown<=cooldown_p. Cooldown decrements on frame_tick_i while >0 and not paused. Shoot edge with cooldown>0 is dropped, not queued.
- HIT:
  - paused_o=1; hit_i and level_clear_i ignored.
  - visible_o toggles every flash_p frame ticks; the flash counter starts at 0 on entry.
  - shoot_rise -> IDLE, visible_o=1, cooldown=0, position kept. This edge does not fire.
- DEAD:
  - alive_o=0, visible_o=0, paused_o=1; all strobes ignored.
  - shoot_rise -> IDLE with lives=lives_p, pos_left=start_left_p, cooldown=0.
- CLEAR:
  - paused_o=1, visible_o=1; hit_i ignored.
  - shoot_rise -> IDLE with pos_left=start_left_p and cooldown=0; lives kept.
- Latency: state, position and lives update on the clock edge after the stimulus. fire_o is registered, asserting the cycle after the shoot edge is sampled.
- Outputs: all except pos_right_o are registered or decoded from registers only.

Test Plan:
1. Reset held then released, no inputs -> state_o=000001, lives_o=3, pos_left_o=304, pos_right_o=335, visible_o=1, fire_o=0.
2. move_left_i held for 100 frame ticks -> pos_left_o falls 4 per tick and sticks at 0. Then move_right_i held for 200 ticks -> saturates at 608, pos_right_o=639. Both buttons held -> IDLE, no movement.
3. shoot_i toggled every cycle for 40 frame ticks -> fire_o pulses only when cooldown allows: exactly one pulse per 16 ticks, 3 total, each 1 cycle wide.
4. hit_i with lives 3 -> HIT, lives_o=2, paused_o=1, visible_o toggles every 8 ticks. shoot_rise -> IDLE, position unchanged, fire_o stays 0. Two more hits -> DEAD, lives_o=0, alive_o=0. shoot_rise -> IDLE, lives_o=3, pos_left_o=304.
5. Same cycle: hit_i, level_clear_i, shoot_rise and frame_tick_i while in RIGHT -> HIT wins, lives decrements, no fire, no position change.
6. Reset asserted mid-HIT and mid-cooldown -> immediate reset values. shoot_i held high across reset release -> no fire_o until shoot_i is released and pressed again.

Source files
------------

// File: rtl/player_ctrl.sv
// player_ctrl: player ship controller. Tracks lives, horizontal position,
// shot cooldown and the hit-flash / level-clear / game-over pauses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | active, ship stationary
// LEFT   | active, ship moves left on each frame tick
// RIGHT  | active, ship moves right on each frame tick
// HIT    | frozen after a hit, ship flashes, shoot edge resumes
// DEAD   | no lives left, ship hidden, shoot edge restarts the game
// CLEAR  | level cleared, frozen, shoot edge starts the next level
module player_ctrl #(
   parameter int lives_p      = 3,
   parameter int screen_w_p   = 640,
   parameter int ship_w_p     = 32,
   parameter int step_p       = 4,
   parameter int start_left_p = 304,
   parameter int cooldown_p   = 16,
   parameter int flash_p      = 8
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       frame_tick_i,
   input  logic       move_left_i,
   input  logic       move_right_i,
   input  logic       shoot_i,
   input  logic       hit_i,
   input  logic       level_clear_i,
   output logic       fire_o,
   output logic       alive_o,
   output logic [3:0] lives_o,
   output logic [9:0] pos_left_o,
   output logic [9:0] pos_right_o,
   output logic       paused_o,
   output logic       visible_o,
   output logic [5:0] state_o
);

   localparam int CoolW  = $clog2(cooldown_p + 1);
   localparam int FlashW = $clog2(flash_p + 1);

   localparam logic [10:0]       MaxLeft   = 11'(screen_w_p - ship_w_p);
   localparam logic [10:0]       Step      = 11'(step_p);
   localparam logic [9:0]        StartLeft = 10'(start_left_p);
   localparam logic [9:0]        ShipSpan  = 10'(ship_w_p - 1);
   localparam logic [3:0]        LivesInit = 4'(lives_p);
   localparam logic [CoolW-1:0]  CoolLoad  = CoolW'(cooldown_p);
   localparam logic [CoolW-1:0]  CoolOne   = CoolW'(1);
   localparam logic [FlashW-1:0] FlashLast = FlashW'(flash_p - 1);
   localparam logic [FlashW-1:0] FlashOne  = FlashW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEFT,
      ST_RIGHT,
      ST_HIT,
      ST_DEAD,
      ST_CLEAR
   } state_e;

   state_e              state_q;
   logic [3:0]          lives_q;
   logic [9:0]          pos_q;
   logic [CoolW-1:0]    cool_q;
   logic [FlashW-1:0]   flash_q;
   logic                visible_q;
   logic                fire_q;
   logic                shoot_q;

   logic                shoot_rise;
   logic [3:0]          lives_dec;
   logic [10:0]         pos_ext;
   logic [10:0]         pos_sum;
   logic [10:0]         pos_dif;
   logic [9:0]          pos_moved;
   state_e              dir_state;

   assign shoot_rise = shoot_i & ~shoot_q;
   assign lives_dec  = lives_q - 4'd1;
   assign pos_ext    = {1'b0, pos_q};
   assign pos_sum    = pos_ext + Step;
   assign pos_dif    = pos_ext - Step;

   // Saturating one-frame move for the present direction; 11-bit so neither end wraps.
   always_comb begin
      pos_moved = pos_q;
      case (state_q)
         ST_LEFT:  pos_moved = (pos_ext < Step) ? 10'd0 : pos_dif[9:0];
         ST_RIGHT: pos_moved = (pos_sum > MaxLeft) ? MaxLeft[9:0] : pos_sum[9:0];
         default:  pos_moved = pos_q;
      endcase
   end

   // Direction requested by the buttons; both or neither means stand still.
   always_comb begin
      dir_state = ST_IDLE;
      if (move_left_i && !move_right_i) begin
         dir_state = ST_LEFT;
      end else if (move_right_i && !move_left_i) begin
         dir_state = ST_RIGHT;
      end
   end

   // Main FSM with all registered state: lives, position, cooldown, flash and fire.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         lives_q   <= LivesInit;
         pos_q     <= StartLeft;
         cool_q    <= '0;
         flash_q   <= '0;
         visible_q <= 1'b1;
         fire_q    <= 1'b0;
         shoot_q   <= 1'b1;
      end else begin
         shoot_q <= shoot_i;
         fire_q  <= 1'b0;
         case (state_q)
            ST_IDLE, ST_LEFT, ST_RIGHT: begin
               if (frame_tick_i && cool_q != '0) begin
                  cool_q <= cool_q - CoolOne;
               end
               if (hit_i) begin
                  lives_q <= lives_dec;
                  flash_q <= '0;
                  if (lives_dec == 4'd0) begin
                     state_q   <= ST_DEAD;
                     visible_q <= 1'b0;
                  end else begin
                     state_q <= ST_HIT;
                  end
               end else if (level_clear_i) begin
                  state_q <= ST_CLEAR;
               end else begin
                  state_q <= dir_state;
                  if (frame_tick_i) begin
                     pos_q <= pos_moved;
                  end
                  // An edge that arrives during cooldown is dropped, not queued.
                  if (shoot_rise && cool_q == '0) begin
                     fire_q <= 1'b1;
                     cool_q <= CoolLoad;
                  end
               end
            end
            ST_HIT: begin
               if (shoot_rise) begin
                  state_q   <= ST_IDLE;
                  visible_q <= 1'b1;
                  cool_q    <= '0;
               end else if (frame_tick_i) begin
                  if (flash_q == FlashLast) begin
                     flash_q   <= '0;
                     visible_q <= ~visible_q;
                  end else begin
                     flash_q <= flash_q + FlashOne;
                  end
               end
            end
            ST_DEAD: begin
               if (shoot_rise) begin
                  state_q   <= ST_IDLE;
                  lives_q   <= LivesInit;
                  pos_q     <= StartLeft;
                  cool_q    <= '0;
                  visible_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (shoot_rise) begin
                  state_q   <= ST_IDLE;
                  pos_q     <= StartLeft;
                  cool_q    <= '0;
                  visible_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               visible_q <= 1'b1;
            end
         endcase
      end
   end

   // One-hot present-state decode, LSB = IDLE.
   always_comb begin
      state_o = 6'b000000;
      case (state_q)
         ST_IDLE:  state_o = 6'b000001;
         ST_LEFT:  state_o = 6'b000010;
         ST_RIGHT: state_o = 6'b000100;
         ST_HIT:   state_o = 6'b001000;
         ST_DEAD:  state_o = 6'b010000;
         ST_CLEAR: state_o = 6'b100000;
         default:  state_o = 6'b000000;
      endcase
   end

   assign fire_o      = fire_q;
   assign alive_o     = (lives_q != 4'd0);
   assign lives_o     = lives_q;
   assign pos_left_o  = pos_q;
   assign pos_right_o = pos_q + ShipSpan;
   assign paused_o    = (state_q == ST_HIT) || (state_q == ST_DEAD) || (state_q == ST_CLEAR);
   assign visible_o   = visible_q;

endmodule
